// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared widths and depths for the FFT commutator buffer path
package fft_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int SEG_DEPTH  = 8;
    localparam int SEG_CNT_W  = 3;
endpackage

// File: rtl/fft_sipo_segment_if.sv
// rtl/fft_sipo_segment_if.sv - serial input / parallel output bundle of the SIPO segment
interface fft_sipo_segment_if
    import fft_pkg::*;
#(
    parameter int DW = DATA_WIDTH
);
    logic          hold;
    logic          clr;
    logic          in_valid;
    logic [DW-1:0] D;
    logic [DW-1:0] Q1, Q2, Q3, Q4, Q5, Q6, Q7, Q8;
    logic          out_valid;
    logic          busy;

    modport master (
        output hold, clr, in_valid, D,
        input  Q1, Q2, Q3, Q4, Q5, Q6, Q7, Q8, out_valid, busy
    );

    modport slave (
        input  hold, clr, in_valid, D,
        output Q1, Q2, Q3, Q4, Q5, Q6, Q7, Q8, out_valid, busy
    );
endinterface

// File: rtl/dff_hold_sync_high_reset.sv
// rtl/dff_hold_sync_high_reset.sv - data register with hold and synchronous active-high reset
module dff_hold_sync_high_reset
    import fft_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_hold,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    always_ff @(posedge clk) begin
        if (rst) begin
            o_q <= '0;
        end else if (!i_hold) begin
            o_q <= i_d;
        end
    end
endmodule

// File: rtl/fft_sipo_segment.sv
// rtl/fft_sipo_segment.sv - packs eight serial words into a parallel bank, Q1 = earliest word
module fft_sipo_segment
    import fft_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    fft_sipo_segment_if.slave bus
);
    logic [SEG_DEPTH-1:0][DATA_WIDTH-1:0] w_s;
    logic [SEG_DEPTH-1:0][DATA_WIDTH-1:0] w_s_shift;
    logic [SEG_DEPTH-1:0][DATA_WIDTH-1:0] w_s_next;
    logic [SEG_DEPTH-1:0][DATA_WIDTH-1:0] w_q;
    logic [SEG_DEPTH-1:0][DATA_WIDTH-1:0] w_q_next;
    logic [SEG_CNT_W-1:0]                 r_count;
    logic                                 r_out_valid;
    logic                                 w_acc;
    logic                                 w_complete;

    assign w_acc      = bus.in_valid & ~bus.hold & ~rst & ~bus.clr;
    assign w_complete = w_acc && (r_count == SEG_CNT_W'(SEG_DEPTH - 1));

    // The bank loads from the shifted view so the eighth word lands in Q8 on its own edge.
    always_comb begin
        w_s_shift = w_s;
        for (int k = 0; k < SEG_DEPTH - 1; k++) begin
            w_s_shift[k] = w_s[k+1];
        end
        w_s_shift[SEG_DEPTH-1] = bus.D;
        w_s_next = w_acc      ? w_s_shift : w_s;
        w_q_next = w_complete ? w_s_shift : w_q;
    end

    for (genvar k = 0; k < SEG_DEPTH; k++) begin : g_stage
        dff_hold_sync_high_reset #(.WIDTH(DATA_WIDTH)) u_s (
            .clk    (clk),
            .rst    (rst),
            .i_hold (bus.hold),
            .i_d    (w_s_next[k]),
            .o_q    (w_s[k])
        );
        dff_hold_sync_high_reset #(.WIDTH(DATA_WIDTH)) u_q (
            .clk    (clk),
            .rst    (rst),
            .i_hold (bus.hold),
            .i_d    (w_q_next[k]),
            .o_q    (w_q[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= '0;
            r_out_valid <= 1'b0;
        end else if (!bus.hold) begin
            if (bus.clr) begin
                r_count     <= '0;
                r_out_valid <= 1'b0;
            end else begin
                r_out_valid <= w_complete;
                if (bus.in_valid) begin
                    r_count <= r_count + SEG_CNT_W'(1);
                end
            end
        end
    end

    assign bus.Q1        = w_q[0];
    assign bus.Q2        = w_q[1];
    assign bus.Q3        = w_q[2];
    assign bus.Q4        = w_q[3];
    assign bus.Q5        = w_q[4];
    assign bus.Q6        = w_q[5];
    assign bus.Q7        = w_q[6];
    assign bus.Q8        = w_q[7];
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = (r_count != '0);
endmodule

// File: tb/tb_fft_sipo_segment.sv
// tb/tb_fft_sipo_segment.sv - directed self-checking bench for fft_sipo_segment
module tb_fft_sipo_segment;
    import fft_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] q_arr [8];

    always #5 clk = ~clk;

    fft_sipo_segment_if bus ();

    fft_sipo_segment dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign q_arr[0] = bus.Q1;
    assign q_arr[1] = bus.Q2;
    assign q_arr[2] = bus.Q3;
    assign q_arr[3] = bus.Q4;
    assign q_arr[4] = bus.Q5;
    assign q_arr[5] = bus.Q6;
    assign q_arr[6] = bus.Q7;
    assign q_arr[7] = bus.Q8;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            step();
            check("idle_ov", {31'b0, bus.out_valid}, 32'd0);
        end
    endtask

    // n back-to-back words first, first+inc, ...; pulse expected only after the last when expect_pulse
    task automatic send_words(input int n, input logic [31:0] first, input logic [31:0] inc,
                              input logic expect_pulse);
        logic [31:0] q1_prev;
        q1_prev = q_arr[0];
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            bus.D        = first + inc * i;
            step();
            if (i == n - 1) begin
                check("ov_last", {31'b0, bus.out_valid}, {31'b0, expect_pulse});
            end else begin
                check("ov_mid", {31'b0, bus.out_valid}, 32'd0);
                check("q1_stable", q_arr[0], q1_prev);
            end
        end
    endtask

    task automatic check_bank(input logic [31:0] first, input logic [31:0] inc);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("bank_q%0d", k + 1), q_arr[k], first + inc * k);
        end
    endtask

    initial begin
        rst          = 1'b1;
        bus.hold     = 1'b0;
        bus.clr      = 1'b0;
        bus.in_valid = 1'b0;
        bus.D        = '0;
        step();
        step();
        rst = 1'b0;
        check_bank(32'h0, 32'h0);
        check("rst_ov", {31'b0, bus.out_valid}, 32'd0);
        check("rst_busy", {31'b0, bus.busy}, 32'd0);

        // basic group 0x11..0x88
        send_words(7, 32'h11, 32'h11, 1'b0);
        check("busy_at7", {31'b0, bus.busy}, 32'd1);
        send_words(1, 32'h88, 32'h0, 1'b1);
        check("busy_done", {31'b0, bus.busy}, 32'd0);
        check_bank(32'h11, 32'h11);
        idle(1);
        check("q1_after_idle", q_arr[0], 32'h11);

        // back-to-back 1..16
        send_words(8, 32'd1, 32'd1, 1'b1);
        check_bank(32'd1, 32'd1);
        send_words(8, 32'd9, 32'd1, 1'b1);
        check_bank(32'd9, 32'd1);
        idle(1);

        // gap of 3 cycles after word 4
        send_words(4, 32'd1, 32'd1, 1'b0);
        idle(3);
        check("gap_busy", {31'b0, bus.busy}, 32'd1);
        send_words(4, 32'd5, 32'd1, 1'b1);
        check_bank(32'd1, 32'd1);
        idle(1);

        // hold at count 5 with a word presented, then resume
        send_words(5, 32'h21, 32'h1, 1'b0);
        bus.hold     = 1'b1;
        bus.in_valid = 1'b1;
        bus.D        = 32'h99;
        for (int i = 0; i < 2; i++) begin
            step();
            check("hold5_ov", {31'b0, bus.out_valid}, 32'd0);
            check("hold5_busy", {31'b0, bus.busy}, 32'd1);
        end
        bus.hold = 1'b0;
        send_words(3, 32'h26, 32'h1, 1'b1);
        check_bank(32'h21, 32'h1);

        // hold in the cycle after a pulse stretches out_valid
        bus.hold     = 1'b1;
        bus.in_valid = 1'b1;
        bus.D        = 32'h77;
        for (int i = 0; i < 2; i++) begin
            step();
            check("hold_ov_stretch", {31'b0, bus.out_valid}, 32'd1);
            check("hold_busy", {31'b0, bus.busy}, 32'd0);
        end
        check("hold_q8", q_arr[7], 32'h28);
        bus.hold = 1'b0;
        idle(1);
        send_words(8, 32'h31, 32'h1, 1'b1);
        check_bank(32'h31, 32'h1);

        // clr after 5 words discards the partial group
        send_words(5, 32'h41, 32'h1, 1'b0);
        bus.clr      = 1'b1;
        bus.in_valid = 1'b1;
        bus.D        = 32'hEE;
        step();
        bus.clr = 1'b0;
        check("clr_ov", {31'b0, bus.out_valid}, 32'd0);
        check("clr_busy", {31'b0, bus.busy}, 32'd0);
        check("clr_q1", q_arr[0], 32'h31);
        send_words(8, 32'hA0, 32'h1, 1'b1);
        check_bank(32'hA0, 32'h1);

        // clr at count 7 with a valid word: no completion
        send_words(7, 32'hB0, 32'h1, 1'b0);
        bus.clr      = 1'b1;
        bus.in_valid = 1'b1;
        bus.D        = 32'hB7;
        step();
        bus.clr = 1'b0;
        check("clr7_ov", {31'b0, bus.out_valid}, 32'd0);
        check("clr7_busy", {31'b0, bus.busy}, 32'd0);
        check("clr7_q8", q_arr[7], 32'hA7);
        idle(1);

        // rst at count 6 clears the bank and the group
        send_words(6, 32'h51, 32'h1, 1'b0);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.D        = 32'h57;
        step();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        check_bank(32'h0, 32'h0);
        check("rst6_ov", {31'b0, bus.out_valid}, 32'd0);
        check("rst6_busy", {31'b0, bus.busy}, 32'd0);
        send_words(8, 32'h61, 32'h1, 1'b1);
        check_bank(32'h61, 32'h1);
        idle(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
